ex_mem: RTL and testbench
=========================

Name: ex_mem

Overview:
- Pipeline register between the execute stage and the memory-access stage of the 5-stage MIPS32 integer pipeline.
- Each clock it captures execute-stage results (GPR write-back and HI/LO write-back) and presents them to the memory stage.
- Implements the pipeline stall/flush/bubble rules.
- Carries the partial-product state for the two-cycle madd/maddu/msub/msubu sequence across its own stall.
- Provides a saturating count of inserted bubbles for performance debug.

Parameters:
- DATA_W, 32, GPR and HI/LO data width.
- ADDR_W, 5, GPR address width.
- STALL_W, 6, width of the pipeline stall vector (pc, if, id, ex, mem, wb).
- EX_BIT, 3, index of the execute-stage stall bit.
- MEM_BIT, 4, index of the memory-stage stall bit.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (rst==0 at a rising edge resets).
- stall  in  STALL_W  per-stage stall request from the stall controller.
- flush  in  1  exception flush, discards the in-flight instruction.
- ex_wd  in  ADDR_W  destination GPR from execute.
- ex_wreg  in  1  GPR write enable from execute.
- ex_wdata  in  DATA_W  GPR write data from execute.
- ex_hi  in  DATA_W  HI write value from execute.
- ex_lo  in  DATA_W  LO write value from execute.
- ex_whilo  in  1  HI/LO write enable from execute.
- hilo_i  in  2*DATA_W  multiply-accumulate partial product from execute.
- cnt_i  in  2  multiply-accumulate cycle index from execute.
- mem_wd  out  ADDR_W  registered destination GPR to memory stage.
- mem_wreg  out  1  registered GPR write enable.
- mem_wdata  out  DATA_W  registered GPR write data.
- mem_hi  out  DATA_W  registered HI value.
- mem_lo  out  DATA_W  registered LO value.
- mem_whilo  out  1  registered HI/LO write enable.
- hilo_o  out  2*DATA_W  partial product fed back to execute.
- cnt_o  out  2  cycle index fed back to execute.
- bubble_cnt  out  CNT_W  number of bubbles inserted since reset.

Behaviour:
- Single always block on posedge clk. Priority, highest first: reset, flush, bubble, hold, advance.
- Reset (rst==0):
  - All outputs go to 0: mem_wd=0 (NOP register), enables deasserted, data zero.
  - hilo_o=0, cnt_o=0, bubble_cnt=0.
- Flush (rst==1, flush==1):
  - mem_* outputs cleared exactly as at reset.
  - hilo_o and cnt_o cleared.
  - bubble_cnt unchanged.
  - Flush overrides every stall combination.
- Bubble (stall[EX_BIT]==1 and stall[MEM_BIT]==0):
  - Execute is stalled but memory proceeds, so mem_* outputs are cleared (NOP) next cycle.
  - hilo_o<=hilo_i and cnt_o<=cnt_i, so multi-cycle MAC progress is retained.
  - bubble_cnt increments by 1 and saturates at 2^CNT_W-1 with no wrap.
- Hold (stall[EX_BIT]==1 and stall[MEM_BIT]==1):
  - All registers keep their value, including hilo_o, cnt_o and bubble_cnt.
- Advance (stall[EX_BIT]==0):
  - All ex_* inputs are captured into their mem_* counterparts.
  - hilo_o and cnt_o are cleared to 0, because the MAC sequence has completed.
  - bubble_cnt unchanged.
- Latency: exactly 1 cycle from an ex_* input to the matching mem_* output when advancing.
- stall bits other than EX_BIT and MEM_BIT are ignored.
- The illegal combination stall[EX_BIT]==0 with stall[MEM_BIT]==1 is treated as advance. No assertion is raised.
- No combinational path from any input to any output.

Test Plan:
- Reset: drive rst=0 for 2 cycles with ex_wd=5, ex_wreg=1, ex_wdata=0xDEADBEEF. Required: all outputs 0, bubble_cnt=0.
- Advance: rst=1, stall=0, ex_wd=7, ex_wreg=1, ex_wdata=0x12345678, ex_whilo=1, ex_hi=0xA, ex_lo=0xB. Required one cycle later: mem_wd=7, mem_wdata=0x12345678, mem_hi=0xA, mem_lo=0xB, mem_whilo=1, hilo_o=0, cnt_o=0.
- MAC bubble: stall=6'b001111 with hilo_i=0x0000_0001_FFFF_FFFE and cnt_i=1. Required: mem_wreg=0, mem_wd=0, hilo_o=0x0000_0001_FFFF_FFFE, cnt_o=1, bubble_cnt=1. Then stall=0. Required: hilo_o=0, cnt_o=0, ex values captured.
- Hold: after an advance with mem_wdata=0x55, apply stall=6'b011111 for 3 cycles while ex_wdata changes. Required: mem_wdata stays 0x55 and bubble_cnt is unchanged.
- Flush priority: stall=6'b011111 with flush=1. Required: all mem_* outputs 0, hilo_o=0, cnt_o=0. With rst=0 and flush=1 together, bubble_cnt=0.
- Saturation: CNT_W=4, apply 20 consecutive bubble cycles. Required: bubble_cnt stops at 15 with no wrap.

Source files
------------

// File: rtl/ex_mem.sv
// EX/MEM pipeline register for the 5-stage MIPS32 integer pipeline.
// Carries GPR/HI-LO write-back, multiply-accumulate state and a bubble counter.
module ex_mem #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int STALL_W = 6,
    parameter int EX_BIT  = 3,
    parameter int MEM_BIT = 4,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall,
    input  logic                flush,
    input  logic [ADDR_W-1:0]   ex_wd,
    input  logic                ex_wreg,
    input  logic [DATA_W-1:0]   ex_wdata,
    input  logic [DATA_W-1:0]   ex_hi,
    input  logic [DATA_W-1:0]   ex_lo,
    input  logic                ex_whilo,
    input  logic [2*DATA_W-1:0] hilo_i,
    input  logic [1:0]          cnt_i,
    output logic [ADDR_W-1:0]   mem_wd,
    output logic                mem_wreg,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W-1:0]   mem_hi,
    output logic [DATA_W-1:0]   mem_lo,
    output logic                mem_whilo,
    output logic [2*DATA_W-1:0] hilo_o,
    output logic [1:0]          cnt_o,
    output logic [CNT_W-1:0]    bubble_cnt
);

    logic [ADDR_W-1:0]   mem_wd_q,     mem_wd_d;
    logic                mem_wreg_q,   mem_wreg_d;
    logic [DATA_W-1:0]   mem_wdata_q,  mem_wdata_d;
    logic [DATA_W-1:0]   mem_hi_q,     mem_hi_d;
    logic [DATA_W-1:0]   mem_lo_q,     mem_lo_d;
    logic                mem_whilo_q,  mem_whilo_d;
    logic [2*DATA_W-1:0] hilo_q,       hilo_d;
    logic [1:0]          cnt_q,        cnt_d;
    logic [CNT_W-1:0]    bubble_cnt_q, bubble_cnt_d;

    logic ex_stall;
    logic mem_stall;

    assign ex_stall  = stall[EX_BIT];
    assign mem_stall = stall[MEM_BIT];

    always_comb begin
        // NOTE: every next-state defaults to the current value, which is the
        // hold behaviour and also keeps this block free of inferred latches.
        mem_wd_d     = mem_wd_q;
        mem_wreg_d   = mem_wreg_q;
        mem_wdata_d  = mem_wdata_q;
        mem_hi_d     = mem_hi_q;
        mem_lo_d     = mem_lo_q;
        mem_whilo_d  = mem_whilo_q;
        hilo_d       = hilo_q;
        cnt_d        = cnt_q;
        bubble_cnt_d = bubble_cnt_q;

        if (flush) begin
            mem_wd_d    = '0;
            mem_wreg_d  = 1'b0;
            mem_wdata_d = '0;
            mem_hi_d    = '0;
            mem_lo_d    = '0;
            mem_whilo_d = 1'b0;
            hilo_d      = '0;
            cnt_d       = '0;
        end else if (ex_stall && !mem_stall) begin
            // Bubble: memory gets a NOP while the MAC progress is kept.
            mem_wd_d    = '0;
            mem_wreg_d  = 1'b0;
            mem_wdata_d = '0;
            mem_hi_d    = '0;
            mem_lo_d    = '0;
            mem_whilo_d = 1'b0;
            hilo_d      = hilo_i;
            cnt_d       = cnt_i;
            if (bubble_cnt_q != {CNT_W{1'b1}}) begin
                bubble_cnt_d = bubble_cnt_q + 1'b1;
            end
        end else if (!ex_stall) begin
            // Advance; a mem-only stall is illegal and also lands here.
            mem_wd_d    = ex_wd;
            mem_wreg_d  = ex_wreg;
            mem_wdata_d = ex_wdata;
            mem_hi_d    = ex_hi;
            mem_lo_d    = ex_lo;
            mem_whilo_d = ex_whilo;
            hilo_d      = '0;
            cnt_d       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_wd_q     <= '0;
            mem_wreg_q   <= 1'b0;
            mem_wdata_q  <= '0;
            mem_hi_q     <= '0;
            mem_lo_q     <= '0;
            mem_whilo_q  <= 1'b0;
            hilo_q       <= '0;
            cnt_q        <= '0;
            bubble_cnt_q <= '0;
        end else begin
            mem_wd_q     <= mem_wd_d;
            mem_wreg_q   <= mem_wreg_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_hi_q     <= mem_hi_d;
            mem_lo_q     <= mem_lo_d;
            mem_whilo_q  <= mem_whilo_d;
            hilo_q       <= hilo_d;
            cnt_q        <= cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign mem_wd     = mem_wd_q;
    assign mem_wreg   = mem_wreg_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_hi     = mem_hi_q;
    assign mem_lo     = mem_lo_q;
    assign mem_whilo  = mem_whilo_q;
    assign hilo_o     = hilo_q;
    assign cnt_o      = cnt_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_ex_mem.sv
// Bench for ex_mem: directed literal checks plus randomized traffic against a
// behavioural model; CNT_W is shrunk to 4 so saturation is reachable.
module tb_ex_mem;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                clk = 1'b0;
    logic                rst;
    logic [5:0]          stall;
    logic                flush;
    logic [ADDR_W-1:0]   ex_wd;
    logic                ex_wreg;
    logic [DATA_W-1:0]   ex_wdata;
    logic [DATA_W-1:0]   ex_hi;
    logic [DATA_W-1:0]   ex_lo;
    logic                ex_whilo;
    logic [2*DATA_W-1:0] hilo_i;
    logic [1:0]          cnt_i;
    logic [ADDR_W-1:0]   mem_wd;
    logic                mem_wreg;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_hi;
    logic [DATA_W-1:0]   mem_lo;
    logic                mem_whilo;
    logic [2*DATA_W-1:0] hilo_o;
    logic [1:0]          cnt_o;
    logic [CNT_W-1:0]    bubble_cnt;

    int n_total = 0;
    int n_bad   = 0;
    bit chk_en  = 1'b0;

    // Model state: what each output must show after the most recent edge.
    logic [ADDR_W-1:0]   m_wd;
    logic                m_wreg;
    logic [DATA_W-1:0]   m_wdata, m_hi, m_lo;
    logic                m_whilo;
    logic [2*DATA_W-1:0] m_hilo;
    logic [1:0]          m_cnt;
    int                  m_bub;

    ex_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STALL_W(6), .EX_BIT(3),
             .MEM_BIT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
        .hilo_i(hilo_i), .cnt_i(cnt_i),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
        .hilo_o(hilo_o), .cnt_o(cnt_o), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_mem_model();
        m_wd = '0; m_wreg = 1'b0; m_wdata = '0;
        m_hi = '0; m_lo = '0; m_whilo = 1'b0;
    endtask

    // Reference behaviour: what the stage does with the inputs seen at an edge.
    always @(posedge clk) begin
        if (rst !== 1'b1) begin
            clear_mem_model();
            m_hilo = '0; m_cnt = '0; m_bub = 0;
        end else if (flush) begin
            clear_mem_model();
            m_hilo = '0; m_cnt = '0;
        end else if (stall[3] && !stall[4]) begin
            clear_mem_model();
            m_hilo = hilo_i; m_cnt = cnt_i;
            m_bub = (m_bub + 1 > CNT_MAX) ? CNT_MAX : m_bub + 1;
        end else if (!stall[3]) begin
            m_wd = ex_wd; m_wreg = ex_wreg; m_wdata = ex_wdata;
            m_hi = ex_hi; m_lo = ex_lo; m_whilo = ex_whilo;
            m_hilo = '0; m_cnt = '0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("mem_wd",     64'(mem_wd),     64'(m_wd));
            check("mem_wreg",   64'(mem_wreg),   64'(m_wreg));
            check("mem_wdata",  64'(mem_wdata),  64'(m_wdata));
            check("mem_hi",     64'(mem_hi),     64'(m_hi));
            check("mem_lo",     64'(mem_lo),     64'(m_lo));
            check("mem_whilo",  64'(mem_whilo),  64'(m_whilo));
            check("hilo_o",     hilo_o,          m_hilo);
            check("cnt_o",      64'(cnt_o),      64'(m_cnt));
            check("bubble_cnt", 64'(bubble_cnt), 64'(m_bub));
        end
    end

    // Inputs change just after the falling edge, so they are stable at the rising edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; stall = '0;
        ex_wd = 5'd5; ex_wreg = 1'b1; ex_wdata = 32'hDEADBEEF;
        ex_hi = '0; ex_lo = '0; ex_whilo = 1'b0; hilo_i = '0; cnt_i = '0;
        @(negedge clk);
        cyc(); cyc();
        chk_en = 1'b1;
        check("rst_wd",    64'(mem_wd), 64'd0);
        check("rst_wreg",  64'(mem_wreg), 64'd0);
        check("rst_wdata", 64'(mem_wdata), 64'd0);
        check("rst_bub",   64'(bubble_cnt), 64'd0);

        rst = 1'b1; ex_wd = 5'd7; ex_wreg = 1'b1; ex_wdata = 32'h12345678;
        ex_whilo = 1'b1; ex_hi = 32'hA; ex_lo = 32'hB;
        cyc();
        check("adv_wd",    64'(mem_wd), 64'd7);
        check("adv_wdata", 64'(mem_wdata), 64'h12345678);
        check("adv_hi",    64'(mem_hi), 64'hA);
        check("adv_lo",    64'(mem_lo), 64'hB);
        check("adv_whilo", 64'(mem_whilo), 64'd1);
        check("adv_hilo",  hilo_o, 64'd0);

        stall = 6'b001111; hilo_i = 64'h0000_0001_FFFF_FFFE; cnt_i = 2'd1;
        cyc();
        check("mac_wreg", 64'(mem_wreg), 64'd0);
        check("mac_wd",   64'(mem_wd), 64'd0);
        check("mac_hilo", hilo_o, 64'h0000_0001_FFFF_FFFE);
        check("mac_cnt",  64'(cnt_o), 64'd1);
        check("mac_bub",  64'(bubble_cnt), 64'd1);

        stall = '0; ex_wd = 5'd9; ex_wdata = 32'h99;
        cyc();
        check("mac_end_hilo",  hilo_o, 64'd0);
        check("mac_end_cnt",   64'(cnt_o), 64'd0);
        check("mac_end_wd",    64'(mem_wd), 64'd9);
        check("mac_end_wdata", 64'(mem_wdata), 64'h99);

        ex_wdata = 32'h55;
        cyc();
        stall = 6'b011111;
        for (int i = 0; i < 3; i++) begin
            ex_wdata = $urandom;
            cyc();
        end
        check("hold_wdata", 64'(mem_wdata), 64'h55);
        check("hold_bub",   64'(bubble_cnt), 64'd1);

        flush = 1'b1;
        cyc();
        check("flush_wd",    64'(mem_wd), 64'd0);
        check("flush_wdata", 64'(mem_wdata), 64'd0);
        check("flush_hilo",  hilo_o, 64'd0);
        check("flush_bub",   64'(bubble_cnt), 64'd1);
        rst = 1'b0;
        cyc();
        check("rst_flush_bub", 64'(bubble_cnt), 64'd0);
        rst = 1'b1; flush = 1'b0;

        stall = 6'b001111;
        for (int i = 0; i < 20; i++) begin
            cnt_i = 2'($urandom);
            cyc();
        end
        check("sat_bub", 64'(bubble_cnt), 64'd15);

        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 63) != 0);
            flush    = ($urandom_range(0, 15) == 0);
            stall    = 6'($urandom);
            ex_wd    = 5'($urandom);
            ex_wreg  = 1'($urandom);
            ex_wdata = $urandom;
            ex_hi    = $urandom;
            ex_lo    = $urandom;
            ex_whilo = 1'($urandom);
            hilo_i   = {$urandom, $urandom};
            cnt_i    = 2'($urandom);
            cyc();
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
